// File: rtl/disparity_frame_sequencer_if.sv
// disparity_frame_sequencer_if: control, gray, block-match strobe and disparity
// stream signals between the frame sequencer and its surroundings.
interface disparity_frame_sequencer_if;
  logic        start;
  logic        abort;
  logic        busy;
  logic        frame_done;
  logic        error;
  logic [7:0]  frame_count;
  logic [7:0]  gray_src_data;
  logic        gray_src_valid;
  logic        gray_src_ready;
  logic [7:0]  gray_dst_data;
  logic        gray_dst_valid;
  logic        gray_dst_ready;
  logic        xors_valid_in;
  logic        xors_valid_out;
  logic [15:0] disp_src_data;
  logic        disp_src_valid;
  logic        disp_src_ready;
  logic [15:0] disp_dst_data;
  logic        disp_dst_valid;
  logic        disp_dst_ready;
  modport slave (
    input  start, abort, gray_src_data, gray_src_valid, gray_dst_ready,
           xors_valid_in, disp_src_data, disp_src_valid, disp_dst_ready,
    output busy, frame_done, error, frame_count, gray_src_ready, gray_dst_data,
           gray_dst_valid, xors_valid_out, disp_src_ready, disp_dst_data, disp_dst_valid
  );
  modport master (
    output start, abort, gray_src_data, gray_src_valid, gray_dst_ready,
           xors_valid_in, disp_src_data, disp_src_valid, disp_dst_ready,
    input  busy, frame_done, error, frame_count, gray_src_ready, gray_dst_data,
           gray_dst_valid, xors_valid_out, disp_src_ready, disp_dst_data, disp_dst_valid
  );
endinterface

// File: rtl/disparity_frame_sequencer.sv
// disparity_frame_sequencer: admits exactly one frame of gray, block-match and
// disparity traffic per start, with a stall watchdog and done/error reporting.
module disparity_frame_sequencer #(
  parameter int FRAME_W          = 240,
  parameter int FRAME_H          = 480,
  parameter int DECIMATE_FACTOR  = 2,
  parameter int BLOCKS_PER_FRAME = 450,
  parameter int TIMEOUT_CYCLES   = 65535
) (
  input logic clk,
  input logic reset,
  disparity_frame_sequencer_if.slave bus
);
  localparam int GRAY_TOT = FRAME_W * FRAME_H;
  localparam int DISP_TOT = (FRAME_W / DECIMATE_FACTOR) * (FRAME_H / DECIMATE_FACTOR);
  localparam int BLK_TOT  = BLOCKS_PER_FRAME;
  localparam int GW = $clog2(GRAY_TOT + 1);
  localparam int DW = $clog2(DISP_TOT + 1);
  localparam int BW = $clog2(BLK_TOT + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GRAY_MAX = GW'(GRAY_TOT);
  localparam logic [DW-1:0] DISP_MAX = DW'(DISP_TOT);
  localparam logic [BW-1:0] BLK_MAX  = BW'(BLK_TOT);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE, ST_ERROR} state_t;

  state_t        r_state;
  logic [GW-1:0] r_gray_cnt;
  logic [DW-1:0] r_disp_cnt;
  logic [BW-1:0] r_blk_cnt;
  logic [WW-1:0] r_wd;
  logic          r_busy;
  logic          r_frame_done;
  logic          r_error;
  logic [7:0]    r_frame_count;

  logic          w_run, w_act;
  logic          w_gray_open, w_blk_open, w_disp_open;
  logic          w_gray_hs, w_blk_hs, w_disp_hs, w_evt, w_wd_to;
  logic [GW-1:0] w_gray_nx;
  logic [DW-1:0] w_disp_nx;
  logic [BW-1:0] w_blk_nx;

  assign w_run       = r_state == ST_RUN;
  assign w_act       = w_run || r_state == ST_DRAIN;
  assign w_gray_open = w_run && r_gray_cnt < GRAY_MAX;
  assign w_blk_open  = w_run && r_blk_cnt < BLK_MAX;
  assign w_disp_open = w_act && r_disp_cnt < DISP_MAX;

  assign bus.gray_dst_data  = bus.gray_src_data;
  assign bus.gray_dst_valid = bus.gray_src_valid & w_gray_open;
  assign bus.gray_src_ready = bus.gray_dst_ready & w_gray_open;
  assign bus.xors_valid_out = bus.xors_valid_in & w_blk_open;
  assign bus.disp_dst_data  = bus.disp_src_data;
  assign bus.disp_dst_valid = bus.disp_src_valid & w_disp_open;
  assign bus.disp_src_ready = bus.disp_dst_ready & w_disp_open;

  assign w_gray_hs = bus.gray_src_valid & bus.gray_dst_ready & w_gray_open;
  assign w_blk_hs  = bus.xors_valid_in & w_blk_open;
  assign w_disp_hs = bus.disp_src_valid & bus.disp_dst_ready & w_disp_open;
  assign w_evt     = w_gray_hs | w_blk_hs | w_disp_hs;
  assign w_wd_to   = w_act && !w_evt && r_wd == WD_LAST;

  // Gates close at the total, so the counters saturate without explicit clamps
  assign w_gray_nx = r_gray_cnt + GW'(w_gray_hs);
  assign w_blk_nx  = r_blk_cnt + BW'(w_blk_hs);
  assign w_disp_nx = r_disp_cnt + DW'(w_disp_hs);

  assign bus.busy        = r_busy;
  assign bus.frame_done  = r_frame_done;
  assign bus.error       = r_error;
  assign bus.frame_count = r_frame_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_gray_cnt    <= '0;
      r_blk_cnt     <= '0;
      r_disp_cnt    <= '0;
      r_wd          <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_error       <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_done <= 1'b0;
      r_gray_cnt   <= w_gray_nx;
      r_blk_cnt    <= w_blk_nx;
      r_disp_cnt   <= w_disp_nx;
      r_wd         <= (w_act && !w_evt) ? r_wd + WW'(1) : '0;
      case (r_state)
        ST_IDLE, ST_ERROR:
          if (bus.start) begin
            r_state    <= ST_RUN;
            r_busy     <= 1'b1;
            r_error    <= 1'b0;
            r_gray_cnt <= '0;
            r_blk_cnt  <= '0;
            r_disp_cnt <= '0;
            r_wd       <= '0;
          end
        ST_RUN, ST_DRAIN:
          if (bus.abort || w_wd_to) begin
            r_state <= ST_ERROR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else if (w_run && w_gray_nx == GRAY_MAX && w_blk_nx == BLK_MAX) begin
            r_state <= ST_DRAIN;
          end else if (!w_run && w_disp_nx == DISP_MAX) begin
            r_state       <= ST_DONE;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 8'd1;
          end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_disparity_frame_sequencer.sv
// tb_disparity_frame_sequencer: directed checks of gating, completion, watchdog,
// abort and reset behaviour on an 8x4 frame (32 gray, 8 disparity, 2 blocks).
module tb_disparity_frame_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  disparity_frame_sequencer_if bus();

  disparity_frame_sequencer #(
    .FRAME_W(8), .FRAME_H(4), .DECIMATE_FACTOR(2), .BLOCKS_PER_FRAME(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int gray_pass = 0, xor_pass = 0, disp_pass = 0, done_cnt = 0, g_bad = 0, d_bad = 0;
  logic [7:0]  exp_g = 8'd0;
  logic [15:0] exp_d = 16'h1234;
  logic [7:0]  g_seq = 8'd0;
  logic [15:0] d_seq = 16'h1234;
  logic l_gdv, l_gsr, l_xo, l_ddv, l_dsr;
  int gb, xb, db, nb, n;
  logic seen;

  always @(posedge clk) begin
    if (bus.gray_dst_valid && bus.gray_dst_ready) begin
      if (bus.gray_dst_data !== exp_g) g_bad <= g_bad + 1;
      exp_g     <= exp_g + 8'd1;
      gray_pass <= gray_pass + 1;
    end
    if (bus.xors_valid_out) xor_pass <= xor_pass + 1;
    if (bus.disp_dst_valid && bus.disp_dst_ready) begin
      if (bus.disp_dst_data !== exp_d) d_bad <= d_bad + 1;
      exp_d     <= exp_d + 16'd1;
      disp_pass <= disp_pass + 1;
    end
    if (bus.frame_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit gv, input bit gr, input bit xv, input bit dv, input bit dr, input bit ab);
    bus.gray_src_valid = gv;
    bus.gray_dst_ready = gr;
    bus.gray_src_data  = g_seq;
    bus.xors_valid_in  = xv;
    bus.disp_src_valid = dv;
    bus.disp_dst_ready = dr;
    bus.disp_src_data  = d_seq;
    bus.abort          = ab;
    #1;
    l_gdv = bus.gray_dst_valid;
    l_gsr = bus.gray_src_ready;
    l_xo  = bus.xors_valid_out;
    l_ddv = bus.disp_dst_valid;
    l_dsr = bus.disp_src_ready;
    @(posedge clk);
    #1;
    if (gv && l_gsr) g_seq++;
    if (dv && l_dsr) d_seq++;
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    idle(1);
    bus.start = 1'b0;
  endtask

  task automatic snap();
    gb = gray_pass; xb = xor_pass; db = disp_pass; nb = done_cnt;
  endtask

  // Streams until frame_done is seen; returns in the DONE cycle
  task automatic stream_frame(input bit rnd, input string tag);
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      if (rnd) cyc($urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(1) != 0,
                   $urandom_range(3) != 0, $urandom_range(3) != 0, 1'b0);
      else cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      seen = bus.frame_done;
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.gray_src_valid = 1'b1; bus.gray_dst_ready = 1'b1; bus.gray_src_data = 8'd0;
    bus.xors_valid_in = 1'b1;
    bus.disp_src_valid = 1'b1; bus.disp_dst_ready = 1'b1; bus.disp_src_data = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.frame_done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_count", bus.frame_count, 0);
    chk("rst_gray_valid", bus.gray_dst_valid, 0);
    chk("rst_gray_ready", bus.gray_src_ready, 0);
    chk("rst_xor", bus.xors_valid_out, 0);
    chk("rst_disp_valid", bus.disp_dst_valid, 0);
    chk("rst_disp_ready", bus.disp_src_ready, 0);
    reset = 1'b1;
    idle(2);

    // exact beat counts with sinks always ready and surplus source traffic
    pulse_start();
    chk("t1_busy", bus.busy, 1);
    snap();
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b1, i < 3, i < 10, 1'b1, 1'b0);
      if (i == 0) chk("t1_gray_open", l_gdv, 1);
      if (i == 2) chk("t1_xor_extra", l_xo, 0);
      if (i == 9) begin
        chk("t1_disp_extra_valid", l_ddv, 0);
        chk("t1_disp_extra_ready", l_dsr, 0);
      end
      if (i == 32) begin
        chk("t1_done_pulse", bus.frame_done, 1);
        chk("t1_count_at_done", bus.frame_count, 1);
      end
      if (i == 33) chk("t1_done_one_cycle", bus.frame_done, 0);
      if (i == 35) begin
        chk("t1_gray_extra_valid", l_gdv, 0);
        chk("t1_gray_extra_ready", l_gsr, 0);
      end
    end
    chk("t1_gray_beats", gray_pass - gb, 32);
    chk("t1_xor_beats", xor_pass - xb, 2);
    chk("t1_disp_beats", disp_pass - db, 8);
    chk("t1_done_count", done_cnt - nb, 1);
    chk("t1_busy_fall", bus.busy, 0);

    // three frames under random backpressure
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    chk("t2_reset_count", bus.frame_count, 0);
    nb = done_cnt;
    for (int f = 0; f < 3; f++) begin
      pulse_start();
      gb = gray_pass; xb = xor_pass; db = disp_pass;
      stream_frame(1'b1, "t2_frame_done");
      idle(1);
      chk("t2_gray_beats", gray_pass - gb, 32);
      chk("t2_xor_beats", xor_pass - xb, 2);
      chk("t2_disp_beats", disp_pass - db, 8);
    end
    chk("t2_frame_count", bus.frame_count, 3);
    chk("t2_done_pulses", done_cnt - nb, 3);
    chk("t2_gray_data_bad", g_bad, 0);
    chk("t2_disp_data_bad", d_bad, 0);
    chk("t2_gray_seq", exp_g, g_seq);
    chk("t2_disp_seq", exp_d, d_seq);

    // watchdog after five gray beats
    pulse_start();
    snap();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (n < 40) begin
      idle(1);
      n++;
      if (bus.error) break;
    end
    chk("t3_wd_cycles", n, 16);
    chk("t3_error", bus.error, 1);
    chk("t3_busy", bus.busy, 0);
    chk("t3_gray_beats", gray_pass - gb, 5);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_gray_valid_closed", l_gdv, 0);
    chk("t3_gray_ready_closed", l_gsr, 0);
    chk("t3_xor_closed", l_xo, 0);
    chk("t3_disp_valid_closed", l_ddv, 0);
    chk("t3_disp_ready_closed", l_dsr, 0);
    chk("t3_error_sticky", bus.error, 1);

    // restart from ERROR runs a complete fresh frame
    pulse_start();
    chk("t4_error_cleared", bus.error, 0);
    chk("t4_busy", bus.busy, 1);
    snap();
    stream_frame(1'b0, "t4_frame_done");
    idle(1);
    chk("t4_gray_beats", gray_pass - gb, 32);
    chk("t4_disp_beats", disp_pass - db, 8);
    chk("t4_frame_count", bus.frame_count, 4);

    // abort coinciding with the last disparity handshake
    pulse_start();
    snap();
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 1'b1, i < 7, 1'b1, 1'b0);
    chk("t5_in_drain_busy", bus.busy, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_error", bus.error, 1);
    chk("t5_no_done", bus.frame_done, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_disp_beats", disp_pass - db, 8);
    idle(3);
    chk("t5_done_count", done_cnt - nb, 0);
    chk("t5_frame_count", bus.frame_count, 4);

    // one-cycle reset in DRAIN
    pulse_start();
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t6_in_drain_busy", bus.busy, 1);
    reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_error", bus.error, 0);
    chk("t6_rst_done", bus.frame_done, 0);
    chk("t6_rst_count", bus.frame_count, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t6_idle_gray_closed", l_gdv, 0);
    chk("t6_idle_disp_closed", l_dsr, 0);

    // start during RUN and on the DONE cycle are ignored
    pulse_start();
    snap();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    bus.start = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;
    chk("t6_run_start_busy", bus.busy, 1);
    stream_frame(1'b0, "t6_frame_done");
    chk("t6_gray_beats", gray_pass - gb, 32);
    chk("t6_disp_beats", disp_pass - db, 8);
    chk("t6_frame_count", bus.frame_count, 1);
    bus.start = 1'b1;
    idle(1);
    bus.start = 1'b0;
    chk("t6_done_start_ignored", bus.busy, 0);
    idle(1);
    chk("t6_still_idle", bus.busy, 0);
    pulse_start();
    chk("t6_idle_start_taken", bus.busy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/disparity_frame_sequencer.md
# disparity_frame_sequencer

Per-frame controller for the disparity filtering datapath. It gates three streams so that exactly one frame's worth of data enters or leaves the filtering system per `start`: the gray pixel stream into the filter, the block-match XOR valid strobes, and the disparity output stream. It tracks completion with beat counters, enforces a stall watchdog and reports frame completion or error to the system controller. It sits between the camera, block-matcher and output writer on one side and the filtering system on the other.

## Interface
- `frame_w`, 240: gray input frame width in pixels.
- `frame_h`, 480: gray input frame height in lines.
- `decimate_factor`, 2: decimation applied by the filter. Output frame is `(frame_w/decimate_factor) x (frame_h/decimate_factor)`.
- `blocks_per_frame`, 450: number of `xors_valid` strobes per frame.
- `timeout_cycles`, 65535: idle cycles in RUN or DRAIN before the block enters ERROR.

Ports:
- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a frame; sampled only in IDLE or ERROR.
- `abort`  in  1  force ERROR from RUN or DRAIN.
- `busy`  out  1  high in RUN or DRAIN.
- `frame_done`  out  1  one-cycle pulse on frame completion.
- `error`  out  1  sticky; cleared by the next accepted `start`.
- `frame_count`  out  8  completed frames, wraps 255 to 0.
- `gray_src_data`  in  8, `gray_src_valid`  in  1, `gray_src_ready`  out  1  gray pixels from the camera.
- `gray_dst_data`  out  8, `gray_dst_valid`  out  1, `gray_dst_ready`  in  1  gray pixels to the filter.
- `xors_valid_in`  in  1, `xors_valid_out`  out  1  block-match strobe, gated.
- `disp_src_data`  in  16, `disp_src_valid`  in  1, `disp_src_ready`  out  1  disparity from the filter.
- `disp_dst_data`  out  16, `disp_dst_valid`  out  1, `disp_dst_ready`  in  1  disparity to the writer.

## Operation
- **Totals.**
  - GRAY_TOT = `frame_w*frame_h`.
  - DISP_TOT = `(frame_w/decimate_factor)*(frame_h/decimate_factor)`.
  - BLK_TOT = `blocks_per_frame`.
  - Each counter is `$clog2(TOT+1)` bits wide and saturates at its total; counters never wrap.
- **States:** IDLE, RUN, DRAIN, DONE, ERROR.
  - IDLE: on `start`, clear all counters and the watchdog, go to RUN.
  - RUN: go to DRAIN when `gray_cnt==GRAY_TOT` and `blk_cnt==BLK_TOT`. This includes the cycle in which the last beat is counted (next-state uses post-increment values).
  - DRAIN: go to DONE when `disp_cnt==DISP_TOT`. Disparity beats are also accepted in RUN.
  - DONE: lasts one cycle. `frame_done` is 1, `frame_count` increments, then go to IDLE.
  - ERROR: `error` is 1 and all gates are closed. On `start`, clear counters and `error`, go to RUN.
- **Gating (combinational, zero latency).**
  - Gray open when in RUN and `gray_cnt<GRAY_TOT`.
    - `gray_dst_valid = gray_src_valid & open`.
    - `gray_src_ready = gray_dst_ready & open`.
    - `gray_dst_data = gray_src_data`.
  - XOR open when in RUN and `blk_cnt<BLK_TOT`: `xors_valid_out = xors_valid_in & open`.
  - Disparity open when in RUN or DRAIN and `disp_cnt<DISP_TOT`. Valid and ready are gated the same way as gray; data passes through.
  - A closed gate drives valid low toward the sink and ready low toward the source.
- **Counting.** Counters increment on handshake (valid & ready on the dst side, gated) or on a gated XOR strobe.
- **Watchdog.**
  - Counts cycles in RUN or DRAIN with no gray handshake, disparity handshake or XOR strobe.
  - Clears on any of those events, and on entry to RUN.
  - Reaching `timeout_cycles` sends the block to ERROR.
- **Priority.** Within a cycle: abort, then watchdog, then completion transition.
- `start` in RUN, DRAIN or DONE is ignored.
- `abort` in IDLE, DONE or ERROR is ignored.

## Timing
- Reset values (held during active-low reset):
  - state IDLE; all counters 0.
  - `busy`, `frame_done`, `error` = 0; `frame_count` = 0.
  - All gates closed: dst valids 0, src readies 0.
- State, counters, `busy`, `error`, `frame_count` and `frame_done` are registered outputs.
- Data/valid/ready paths are combinational pass-throughs, with no added latency and no buffering.
- `start` at cycle N gives `busy`=1 and gates open at cycle N+1.
- Last disparity handshake at cycle N (in DRAIN): DONE with `frame_done`=1 at N+1, IDLE at N+2, `frame_count` updated at N+1.
- If the last disparity beat occurs in RUN before gray/XOR finish: RUN goes to DRAIN, and DRAIN sees `disp_cnt==DISP_TOT` and goes to DONE on the next cycle.
- `start` on the same cycle as DONE is ignored. It is accepted from the following IDLE cycle.
- Reset mid-frame returns to IDLE within one cycle. Partial beats already passed are not recovered.

## Test plan
- Frame size 8x4, `decimate_factor` 2, `blocks_per_frame` 2, `timeout_cycles` 16 (GRAY_TOT 32, DISP_TOT 8). Pulse `start`, then stream 40 gray beats, 3 XOR strobes and 10 disparity beats with sinks always ready. Required:
  - exactly 32 gray, 2 XOR and 8 disparity beats pass;
  - extras see ready/valid 0;
  - one `frame_done` pulse, `frame_count`=1, `busy` falls.
- Random valid and ready backpressure on both streams over 3 frames. Required:
  - data matches end to end, with no drop or duplicate;
  - `frame_count`=3;
  - `frame_done` asserts exactly 3 times.
- Start a frame, then hold all inputs idle after 5 gray beats. Required: ERROR after 16 idle cycles, `error`=1, gates closed.
- Then pulse `start`. Required: `error`=0, counters cleared, and a full frame completes.
- `abort` on the same cycle as the last disparity handshake. Required: ERROR, no `frame_done`, `frame_count` unchanged.
- Drive reset low mid-DRAIN for 1 cycle. Required: all outputs at reset values next cycle; `start` during RUN ignored; `start` on the DONE cycle ignored.
